// File: rtl/inst_issue_queue.sv
// Instruction issue queue: accepts host instructions over valid/ready, buffers
// them in a circular FIFO and hands them one at a time to the processor. Each
// instruction is held on inst until the processor reports done. A watchdog
// drops any instruction whose done never arrives.
module inst_issue_queue #(
    parameter int IW      = 34,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IW-1:0]            host_inst,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [IW-1:0]            inst,
    output logic                     issue,
    input  logic                     proc_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err,
    output logic [15:0]              issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [15:0]   TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    // FIFO storage; contents are never reset, only the pointers are
    logic [IW-1:0] mem [DEPTH];

    state_t          state_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [15:0]     wdog_reg;
    logic [IW-1:0]   inst_reg;
    logic            issue_reg;
    logic            terr_reg;
    logic [15:0]     issued_reg;
    logic            alive_reg;

    logic push;
    logic pop;
    logic has_entry;
    logic waiting;
    logic expired;
    logic finish;

    // Handshake and issue decisions, all derived from registered state
    always_comb begin
        host_ready = alive_reg && (count_reg < DEPTH_C);
        push       = host_valid && host_ready;
        has_entry  = (count_reg != '0);
        waiting    = (state_reg == WAIT_DONE);
        // A done arriving in the expiry cycle wins over the abort
        expired    = waiting && !proc_done && (wdog_reg == TIMEOUT_C);
        finish     = waiting && (proc_done || expired);
        pop        = has_entry && ((state_reg == IDLE) || finish);
    end

    // Occupancy update: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= host_inst;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            alive_reg  <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Issue FSM: registered read of the head entry, watchdog and status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wdog_reg   <= '0;
            inst_reg   <= '0;
            issue_reg  <= 1'b0;
            terr_reg   <= 1'b0;
            issued_reg <= '0;
        end else begin
            issue_reg <= pop;
            if (pop) begin
                inst_reg <= mem[rd_ptr_reg];
            end
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg <= WAIT_DONE;
                        wdog_reg  <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (proc_done) begin
                        issued_reg <= issued_reg + 16'd1;
                    end
                    if (expired) begin
                        terr_reg <= 1'b1;
                    end
                    if (finish) begin
                        if (pop) begin
                            wdog_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        wdog_reg <= wdog_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output mapping
    always_comb begin
        inst        = inst_reg;
        issue       = issue_reg;
        busy        = (state_reg == WAIT_DONE);
        count       = count_reg;
        timeout_err = terr_reg;
        issued_cnt  = issued_reg;
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Testbench for inst_issue_queue: table-driven directed vectors, hand-written
// timeout/reset/stream sequences and random traffic, all checked against a
// queue-based reference model.
module tb_inst_issue_queue;

    localparam int IW      = 34;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [IW-1:0] host_inst = '0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [IW-1:0] inst;
    logic          issue;
    logic          proc_done = 1'b0;
    logic          busy;
    logic [CW-1:0] count;
    logic          timeout_err;
    logic [15:0]   issued_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    inst_issue_queue #(.IW(IW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_inst   (host_inst),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .inst        (inst),
        .issue       (issue),
        .proc_done   (proc_done),
        .busy        (busy),
        .count       (count),
        .timeout_err (timeout_err),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending instructions plus the outstanding one
    logic [IW-1:0] m_q[$];
    logic [IW-1:0] m_inst;
    logic          m_busy;
    logic          m_issue;
    logic          m_terr;
    logic          m_alive;
    logic [15:0]   m_icnt;
    int            m_wd;

    task automatic model_reset();
        m_q.delete();
        m_inst  = '0;
        m_busy  = 1'b0;
        m_issue = 1'b0;
        m_terr  = 1'b0;
        m_alive = 1'b0;
        m_icnt  = '0;
        m_wd    = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later
    task automatic step(input logic v, input logic [IW-1:0] d, input logic dn);
        logic do_push;
        logic fin;
        host_valid = v;
        host_inst  = d;
        proc_done  = dn;
        @(posedge clk);
        do_push = v && m_alive && (m_q.size() < DEPTH);
        m_issue = 1'b0;
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                m_inst  = m_q.pop_front();
                m_issue = 1'b1;
                m_busy  = 1'b1;
                m_wd    = 0;
            end
        end else begin
            fin = 1'b0;
            if (dn) begin
                m_icnt = m_icnt + 16'd1;
                fin    = 1'b1;
            end else if (m_wd == TIMEOUT) begin
                m_terr = 1'b1;
                fin    = 1'b1;
            end
            if (fin) begin
                if (m_q.size() > 0) begin
                    m_inst  = m_q.pop_front();
                    m_issue = 1'b1;
                    m_wd    = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_wd++;
            end
        end
        if (do_push) m_q.push_back(d);
        m_alive = 1'b1;
        #1;
        chk("model_inst",   64'(inst),        64'(m_inst));
        chk("model_issue",  64'(issue),       64'(m_issue));
        chk("model_busy",   64'(busy),        64'(m_busy));
        chk("model_count",  64'(count),       64'(m_q.size()));
        chk("model_terr",   64'(timeout_err), 64'(m_terr));
        chk("model_icnt",   64'(issued_cnt),  64'(m_icnt));
        chk("model_ready",  64'(host_ready),  64'(m_q.size() < DEPTH));
    endtask

    // Asynchronous reset between clock edges, with immediate output check
    task automatic apply_reset();
        host_valid = 1'b0;
        proc_done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inst",  64'(inst),        64'd0);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_count", 64'(count),       64'd0);
        chk("rst_issue", 64'(issue),       64'd0);
        chk("rst_terr",  64'(timeout_err), 64'd0);
        chk("rst_icnt",  64'(issued_cnt),  64'd0);
        chk("rst_ready", 64'(host_ready),  64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic          v;
        logic [IW-1:0] d;
        logic          dn;
        logic [IW-1:0] e_inst;
        logic          e_issue;
        logic          e_busy;
        logic          e_ready;
        int            e_count;
        int            e_icnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [IW-1:0] d, logic dn, logic [IW-1:0] ei,
                                logic eis, logic eb, logic er, int ec, int eic);
        vec_t r;
        r.v = v; r.d = d; r.dn = dn; r.e_inst = ei; r.e_issue = eis;
        r.e_busy = eb; r.e_ready = er; r.e_count = ec; r.e_icnt = eic;
        return r;
    endfunction

    function automatic logic [IW-1:0] bval(int k);
        return 34'h1_0000_0100 + IW'(k);
    endfunction

    vec_t tbl[17];

    initial begin : main
        logic [IW-1:0] a_inst;
        logic [IW-1:0] sent[$];
        logic [IW-1:0] got[$];
        int n_sent;
        int cyc;

        a_inst = 34'h2_0000_0001;
        model_reset();
        apply_reset();

        // Directed table: single issue, fill to full, done-driven drain, push+done
        tbl[0] = mk(1, a_inst, 0, '0,     0, 0, 1, 1, 0);
        tbl[1] = mk(0, '0,     0, a_inst, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            tbl[2+i] = mk(1, bval(i), 0, a_inst, 0, 1, (i < 7), i + 1, 0);
        tbl[10] = mk(1, bval(8), 0, a_inst,  0, 1, 0, 8, 0);
        tbl[11] = mk(1, bval(8), 1, bval(0), 1, 1, 1, 7, 1);
        tbl[12] = mk(0, '0,      1, bval(1), 1, 1, 1, 6, 2);
        tbl[13] = mk(0, '0,      1, bval(2), 1, 1, 1, 5, 3);
        tbl[14] = mk(0, '0,      1, bval(3), 1, 1, 1, 4, 4);
        tbl[15] = mk(0, '0,      1, bval(4), 1, 1, 1, 3, 5);
        tbl[16] = mk(1, bval(8), 1, bval(5), 1, 1, 1, 3, 6);
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].dn);
            chk($sformatf("tbl%0d_inst", i),  64'(inst),       64'(tbl[i].e_inst));
            chk($sformatf("tbl%0d_issue", i), 64'(issue),      64'(tbl[i].e_issue));
            chk($sformatf("tbl%0d_busy", i),  64'(busy),       64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_ready", i), 64'(host_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_count", i), 64'(count),      64'(tbl[i].e_count));
            chk($sformatf("tbl%0d_icnt", i),  64'(issued_cnt), 64'(tbl[i].e_icnt));
        end

        // Watchdog: no abort after 255 silent cycles, abort on the next one
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, '0, 1'b0);
        chk("to_not_yet", 64'(timeout_err), 64'd0);
        step(1'b0, '0, 1'b0);
        chk("to_err",   64'(timeout_err), 64'd1);
        chk("to_inst",  64'(inst),        64'(bval(6)));
        chk("to_issue", 64'(issue),       64'd1);
        chk("to_icnt",  64'(issued_cnt),  64'd6);
        chk("to_count", 64'(count),       64'd2);

        // Fill to five queued entries while waiting, then reset mid-flight
        for (int i = 0; i < 3; i++) step(1'b1, 34'h0_00C0_0000 + IW'(i), 1'b0);
        chk("pre_rst_count", 64'(count), 64'd5);
        chk("pre_rst_busy",  64'(busy),  64'd1);
        apply_reset();

        // Stream 20 instructions with a done every third cycle
        n_sent = 0;
        cyc = 0;
        while (m_icnt < 20 && cyc < 400) begin
            logic v;
            logic [IW-1:0] d;
            v = (n_sent < 20);
            d = 34'h3_0000_0000 + IW'(n_sent);
            if (v && host_ready) begin
                sent.push_back(d);
                n_sent++;
            end
            step(v, d, (cyc % 3) == 2);
            if (issue) got.push_back(inst);
            cyc++;
        end
        chk("stream_icnt",   64'(issued_cnt), 64'd20);
        chk("stream_nissue", 64'(got.size()), 64'd20);
        for (int i = 0; i < 20 && i < got.size(); i++)
            chk($sformatf("stream_order%0d", i), 64'(got[i]), 64'(34'h3_0000_0000 + IW'(i)));

        // Done arriving in the expiry cycle counts as a normal completion
        step(1'b1, 34'h1_2345_6789, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("edge_issue", 64'(issue), 64'd1);
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("edge_terr", 64'(timeout_err), 64'd0);
        chk("edge_icnt", 64'(issued_cnt),  64'd21);
        chk("edge_busy", 64'(busy),        64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [IW-1:0] d;
            d = {2'($urandom_range(0, 3)), 32'($urandom)};
            step(($urandom_range(0, 2) != 0), d, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
